// File: rtl/timer_irq_unit.sv
// timer_irq_unit: bus-mapped tick timer with periodic interrupt.
//   Counts prescaler ticks into a 16-bit TimerCount, fires a period event
//   every IntPeriod ticks and raises IRQ_RAISE until IRQ_ACK.
//   Register map at BASE_ADDR+0..3: count low/clear, shadow high byte,
//   IntPeriod, control {5'b0, OneShot, Overrun, IrqEn}.
// Ports:
//   CLK, RESET (async, active-high)
//   TICK_IN        one-cycle prescaler tick
//   BUS_ADDR/BUS_DATA_IN/BUS_WE/BUS_RE   register access
//   BUS_DATA_OUT/BUS_DATA_OE             registered read data, valid one cycle
//   IRQ_RAISE/IRQ_ACK                    interrupt handshake
// Optional feature: define TIMER_IRQ_ONESHOT_EN to add the OneShot control bit.
module timer_irq_unit #(
    parameter logic [7:0] BASE_ADDR      = 8'hF0,
    parameter logic [7:0] DEFAULT_PERIOD = 8'd100,
    parameter logic       DEFAULT_IRQ_EN = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TICK_IN,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA_IN,
    input  logic       BUS_WE,
    input  logic       BUS_RE,
    output logic [7:0] BUS_DATA_OUT,
    output logic       BUS_DATA_OE,
    output logic       IRQ_RAISE,
    input  logic       IRQ_ACK
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned REG_W = 8;

    typedef enum logic {S_IDLE = 1'b0, S_RAISED = 1'b1} state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   timer_q, timer_n;
    logic [REG_W-1:0]   pcnt_q, pcnt_n;
    logic [REG_W-1:0]   shadow_q, shadow_n;
    logic [REG_W-1:0]   period_q, period_n;
    logic               irq_en_q, irq_en_n;
    logic               overrun_q, overrun_n;
    logic [REG_W-1:0]   dout_n;
    logic               oe_n;
    logic               oneshot_q;
`ifdef TIMER_IRQ_ONESHOT_EN
    logic               oneshot_n;
`else
    assign oneshot_q = 1'b0;
`endif

    // Address decode; subtraction makes the range check wrap-safe.
    logic [REG_W-1:0]   addr_off;
    logic [1:0]         reg_sel;
    logic               hit, rd_hit, wr_hit, wr_clr, wr_period, wr_ctrl;
    logic               en_kill, period_event, ev_live;
    logic [REG_W-1:0]   ctrl_word;

    assign addr_off  = BUS_ADDR - BASE_ADDR;
    assign reg_sel   = addr_off[1:0];
    assign hit       = (addr_off < REG_W'(4));
    assign rd_hit    = BUS_RE && hit;
    assign wr_hit    = BUS_WE && hit;
    assign wr_clr    = wr_hit && (reg_sel == 2'd0);
    assign wr_period = wr_hit && (reg_sel == 2'd2);
    assign wr_ctrl   = wr_hit && (reg_sel == 2'd3);
    assign ctrl_word = {5'b0, oneshot_q, overrun_q, irq_en_q};

    // Writing IrqEn=0 drops any interrupt and the event of that edge.
    assign en_kill = wr_ctrl && !BUS_DATA_IN[0];

    // >= (not ==) so a period shrunk below the current count wraps on the next tick.
    assign period_event = TICK_IN && !wr_clr && (period_q != '0) &&
                          (pcnt_q >= (period_q - REG_W'(1)));
    assign ev_live      = period_event && irq_en_q && !en_kill;

    assign IRQ_RAISE = (state_q == S_RAISED);

    // Next-state and register update logic.
    always_comb begin
        state_n   = state_q;
        timer_n   = timer_q;
        pcnt_n    = pcnt_q;
        shadow_n  = shadow_q;
        period_n  = period_q;
        irq_en_n  = irq_en_q;
        overrun_n = overrun_q;
        dout_n    = BUS_DATA_OUT;
        oe_n      = 1'b0;
`ifdef TIMER_IRQ_ONESHOT_EN
        oneshot_n = oneshot_q;
        if (wr_ctrl) oneshot_n = BUS_DATA_IN[2];
`endif

        // Counters: clear beats a simultaneous tick.
        if (wr_clr) begin
            timer_n = '0;
            pcnt_n  = '0;
        end else if (TICK_IN) begin
            timer_n = timer_q + CNT_W'(1);
            if (period_event || (period_q == '0)) pcnt_n = '0;
            else                                  pcnt_n = pcnt_q + REG_W'(1);
        end

        // Reads see pre-write values.
        if (rd_hit) begin
            oe_n = 1'b1;
            case (reg_sel)
                2'd0: begin
                    dout_n   = timer_q[7:0];
                    shadow_n = timer_q[15:8];
                end
                2'd1:    dout_n = shadow_q;
                2'd2:    dout_n = period_q;
                default: dout_n = ctrl_word;
            endcase
        end

        if (wr_period) period_n = BUS_DATA_IN;

        if (wr_ctrl)                     irq_en_n = BUS_DATA_IN[0];
        else if (oneshot_q && ev_live)   irq_en_n = 1'b0;

        if (wr_ctrl && BUS_DATA_IN[1]) overrun_n = 1'b0;

        // Interrupt handshake; overrun set is placed after the clear so set wins.
        case (state_q)
            S_IDLE: begin
                if (ev_live) state_n = S_RAISED;
            end
            S_RAISED: begin
                if (ev_live) begin
                    if (!IRQ_ACK) overrun_n = 1'b1;
                end else if (IRQ_ACK) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (en_kill) state_n = S_IDLE;
    end

    // State registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            pcnt_q       <= '0;
            shadow_q     <= '0;
            period_q     <= DEFAULT_PERIOD;
            irq_en_q     <= DEFAULT_IRQ_EN;
            overrun_q    <= 1'b0;
            BUS_DATA_OUT <= '0;
            BUS_DATA_OE  <= 1'b0;
        end else begin
            state_q      <= state_n;
            timer_q      <= timer_n;
            pcnt_q       <= pcnt_n;
            shadow_q     <= shadow_n;
            period_q     <= period_n;
            irq_en_q     <= irq_en_n;
            overrun_q    <= overrun_n;
            BUS_DATA_OUT <= dout_n;
            BUS_DATA_OE  <= oe_n;
        end
    end

`ifdef TIMER_IRQ_ONESHOT_EN
    // OneShot control bit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) oneshot_q <= 1'b0;
        else       oneshot_q <= oneshot_n;
    end
`endif

endmodule
